match_control: RTL and testbench

MATCH_CONTROL -- requirements
Module: match_control

---
 rtl/match_control.sv | 188 ++++++++++++++++++
 tb/tb_match_control.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/match_control.sv
// -----------------------------------------------------------------------------
// match_control
//   Match sequencer for a two-paddle ball game. Tracks the menu screen, serve,
//   rally, post-point pause and game-over result screen, keeps both scores and
//   decides who serves next. Every output is a register.
//
// Parameters
//   WIN_POINTS   : score that ends a match (1..15)
//   PAUSE_FRAMES : frames the ball is held after a point (1..255)
//   OVER_FRAMES  : frames the game-over screen is shown (1..1023)
//
// Ports
//   clk65MHz        in   system clock, rising edge
//   rst             in   synchronous reset, active low
//   end_of_frame    in   one-cycle pulse per video frame
//   start_single    in   level: start a single-player match
//   start_multi     in   level: start a two-player match (wins over single)
//   serve           in   level serve button (rising edge is used)
//   point_p1        in   pulse: player 1 won the rally
//   point_p2        in   pulse: player 2 won the rally
//   screen_idle     out  menu screen shown
//   screen_multi    out  1 = two-player mode
//   ball_run        out  ball may move
//   server          out  0 = player 1 serves, 1 = player 2 serves
//   points_player_1 out  player 1 score
//   points_player_2 out  player 2 score
//   game_over       out  result screen shown
//   winner          out  0 = player 1 won, 1 = player 2 won
// -----------------------------------------------------------------------------
module match_control #(
  parameter int WIN_POINTS   = 11,
  parameter int PAUSE_FRAMES = 60,
  parameter int OVER_FRAMES  = 180
) (
  input  logic       clk65MHz,
  input  logic       rst,
  input  logic       end_of_frame,
  input  logic       start_single,
  input  logic       start_multi,
  input  logic       serve,
  input  logic       point_p1,
  input  logic       point_p2,
  output logic       screen_idle,
  output logic       screen_multi,
  output logic       ball_run,
  output logic       server,
  output logic [3:0] points_player_1,
  output logic [3:0] points_player_2,
  output logic       game_over,
  output logic       winner
);

  typedef enum logic [2:0] {
    IDLE,
    SERVE_WAIT,
    RALLY,
    POINT_PAUSE,
    GAME_OVER
  } state_t;

  localparam logic [3:0] WIN_SCORE  = 4'(WIN_POINTS);
  // Counters compare against "last pulse index" so the terminal pulse itself
  // triggers the transition.
  localparam logic [7:0] PAUSE_LAST = 8'(PAUSE_FRAMES - 1);
  localparam logic [9:0] OVER_LAST  = 10'(OVER_FRAMES - 1);

  state_t     state_reg, state_next;
  logic       serve_reg;
  logic [7:0] pause_cnt_reg, pause_cnt_next;
  logic [9:0] over_cnt_reg, over_cnt_next;

  logic       screen_multi_next;
  logic       server_next;
  logic [3:0] points_1_next, points_2_next;
  logic       winner_next;
  logic       serve_edge;
  logic       someone_won;

  always_comb begin
    state_next        = state_reg;
    screen_multi_next = screen_multi;
    server_next       = server;
    points_1_next     = points_player_1;
    points_2_next     = points_player_2;
    winner_next       = winner;
    serve_edge        = serve & ~serve_reg;
    someone_won       = (points_player_1 == WIN_SCORE) || (points_player_2 == WIN_SCORE);

    case (state_reg)
      IDLE: begin
        if (start_multi || start_single) begin
          state_next        = SERVE_WAIT;
          screen_multi_next = start_multi;
          server_next       = 1'b0;
          points_1_next     = 4'd0;
          points_2_next     = 4'd0;
          winner_next       = 1'b0;
        end
      end

      SERVE_WAIT: begin
        if (serve_edge) begin
          state_next = RALLY;
        end
      end

      RALLY: begin
        // Player 1 takes precedence on a simultaneous report; the rally
        // loser serves next. Scores saturate rather than wrap.
        if (point_p1) begin
          state_next    = POINT_PAUSE;
          server_next   = 1'b1;
          points_1_next = (points_player_1 == 4'd15) ? 4'd15 : points_player_1 + 4'd1;
        end else if (point_p2) begin
          state_next    = POINT_PAUSE;
          server_next   = 1'b0;
          points_2_next = (points_player_2 == 4'd15) ? 4'd15 : points_player_2 + 4'd1;
        end
      end

      POINT_PAUSE: begin
        if (end_of_frame && (pause_cnt_reg == PAUSE_LAST)) begin
          if (someone_won) begin
            state_next  = GAME_OVER;
            winner_next = (points_player_1 != WIN_SCORE);
          end else begin
            state_next = SERVE_WAIT;
          end
        end
      end

      GAME_OVER: begin
        if (serve_edge || (end_of_frame && (over_cnt_reg == OVER_LAST))) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase

    // Frame counters restart on any state change and advance only on frame
    // pulses while in their own state.
    if (state_next != state_reg) begin
      pause_cnt_next = 8'd0;
      over_cnt_next  = 10'd0;
    end else begin
      pause_cnt_next = pause_cnt_reg;
      over_cnt_next  = over_cnt_reg;
      if (end_of_frame && (state_reg == POINT_PAUSE)) begin
        pause_cnt_next = pause_cnt_reg + 8'd1;
      end
      if (end_of_frame && (state_reg == GAME_OVER)) begin
        over_cnt_next = over_cnt_reg + 10'd1;
      end
    end
  end

  always_ff @(posedge clk65MHz) begin
    if (!rst) begin
      state_reg       <= IDLE;
      serve_reg       <= 1'b0;
      pause_cnt_reg   <= 8'd0;
      over_cnt_reg    <= 10'd0;
      screen_idle     <= 1'b1;
      screen_multi    <= 1'b0;
      ball_run        <= 1'b0;
      server          <= 1'b0;
      points_player_1 <= 4'd0;
      points_player_2 <= 4'd0;
      game_over       <= 1'b0;
      winner          <= 1'b0;
    end else begin
      state_reg       <= state_next;
      serve_reg       <= serve;
      pause_cnt_reg   <= pause_cnt_next;
      over_cnt_reg    <= over_cnt_next;
      screen_idle     <= (state_next == IDLE);
      screen_multi    <= screen_multi_next;
      ball_run        <= (state_next == RALLY);
      server          <= server_next;
      points_player_1 <= points_1_next;
      points_player_2 <= points_2_next;
      game_over       <= (state_next == GAME_OVER);
      winner          <= winner_next;
    end
  end

endmodule

// File: tb/tb_match_control.sv
// -----------------------------------------------------------------------------
// tb_match_control
//   Self-checking bench for match_control. A behavioural match model tracks
//   the game at the level of "what is on screen, who has how many points" and
//   is compared with the DUT on every falling edge. Directed scenarios with
//   literal expectations are followed by a long randomized run.
// -----------------------------------------------------------------------------
module tb_match_control;

  localparam int WIN   = 11;
  localparam int PAUSE = 60;
  localparam int OVER  = 180;

  localparam int PH_IDLE  = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_RALLY = 2;
  localparam int PH_PAUSE = 3;
  localparam int PH_OVER  = 4;

  logic       clk65MHz = 1'b0;
  logic       rst = 1'b0;
  logic       end_of_frame = 1'b0;
  logic       start_single = 1'b0;
  logic       start_multi = 1'b0;
  logic       serve = 1'b0;
  logic       point_p1 = 1'b0;
  logic       point_p2 = 1'b0;
  logic       screen_idle, screen_multi, ball_run, server, game_over, winner;
  logic [3:0] points_player_1, points_player_2;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  // model state
  int m_phase = PH_IDLE;
  int m_frames = 0;
  int m_p1 = 0, m_p2 = 0;
  int m_multi = 0, m_server = 0, m_winner = 0;
  bit m_serve_prev = 1'b0;

  match_control #(
    .WIN_POINTS  (WIN),
    .PAUSE_FRAMES(PAUSE),
    .OVER_FRAMES (OVER)
  ) dut (
    .clk65MHz       (clk65MHz),
    .rst            (rst),
    .end_of_frame   (end_of_frame),
    .start_single   (start_single),
    .start_multi    (start_multi),
    .serve          (serve),
    .point_p1       (point_p1),
    .point_p2       (point_p2),
    .screen_idle    (screen_idle),
    .screen_multi   (screen_multi),
    .ball_run       (ball_run),
    .server         (server),
    .points_player_1(points_player_1),
    .points_player_2(points_player_2),
    .game_over      (game_over),
    .winner         (winner)
  );

  always #5 clk65MHz = ~clk65MHz;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: advances on each rising edge from the inputs that the
  // DUT sees on that same edge.
  always @(posedge clk65MHz) begin
    bit serve_pressed;
    serve_pressed = serve && !m_serve_prev;
    if (!rst) begin
      m_phase = PH_IDLE; m_frames = 0; m_p1 = 0; m_p2 = 0;
      m_multi = 0; m_server = 0; m_winner = 0; serve_pressed = 1'b0;
      m_serve_prev = 1'b0;
    end else begin
      case (m_phase)
        PH_IDLE:
          if (start_multi || start_single) begin
            m_phase = PH_WAIT; m_multi = start_multi ? 1 : 0;
            m_p1 = 0; m_p2 = 0; m_server = 0; m_winner = 0;
          end
        PH_WAIT:
          if (serve_pressed) m_phase = PH_RALLY;
        PH_RALLY:
          if (point_p1) begin
            m_p1 = (m_p1 < 15) ? m_p1 + 1 : 15; m_server = 1;
            m_phase = PH_PAUSE; m_frames = 0;
          end else if (point_p2) begin
            m_p2 = (m_p2 < 15) ? m_p2 + 1 : 15; m_server = 0;
            m_phase = PH_PAUSE; m_frames = 0;
          end
        PH_PAUSE: begin
          if (end_of_frame) m_frames++;
          if (m_frames == PAUSE) begin
            if (m_p1 == WIN || m_p2 == WIN) begin
              m_phase = PH_OVER; m_winner = (m_p1 == WIN) ? 0 : 1;
            end else begin
              m_phase = PH_WAIT;
            end
            m_frames = 0;
          end
        end
        PH_OVER: begin
          if (end_of_frame) m_frames++;
          if (m_frames == OVER || serve_pressed) begin
            m_phase = PH_IDLE; m_frames = 0;
          end
        end
        default: m_phase = PH_IDLE;
      endcase
      m_serve_prev = serve;
    end
    check_en = 1'b1;
  end

  // Continuous comparison of every output against the model.
  always @(negedge clk65MHz) begin
    if (check_en) begin
      chk("screen_idle", int'(screen_idle), (m_phase == PH_IDLE) ? 1 : 0);
      chk("screen_multi", int'(screen_multi), m_multi);
      chk("ball_run", int'(ball_run), (m_phase == PH_RALLY) ? 1 : 0);
      chk("server", int'(server), m_server);
      chk("points_player_1", int'(points_player_1), m_p1);
      chk("points_player_2", int'(points_player_2), m_p2);
      chk("game_over", int'(game_over), (m_phase == PH_OVER) ? 1 : 0);
      chk("winner", int'(winner), m_winner);
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk65MHz);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      end_of_frame = 1'b1;
      tick(1);
      end_of_frame = 1'b0;
      tick(int'($urandom_range(0, 2)));
    end
  endtask

  // Press serve fresh, let the given player win the rally, sit out the pause.
  task automatic play_point(input int who);
    serve = 1'b0; tick(1);
    serve = 1'b1; tick(1);
    if (who == 1) point_p1 = 1'b1; else point_p2 = 1'b1;
    tick(1);
    point_p1 = 1'b0; point_p2 = 1'b0;
    frames(PAUSE);
  endtask

  initial begin
    tick(2);
    rst = 1'b1;
    tick(1);

    // Two-player start and first serve
    start_multi = 1'b1; tick(1); start_multi = 1'b0;
    tick(2);
    serve = 1'b1; tick(1);
    chk("lit_serve_ball_run", int'(ball_run), 1);
    chk("lit_serve_screen_idle", int'(screen_idle), 0);
    chk("lit_serve_multi", int'(screen_multi), 1);

    // Player 2 point, pause, then held serve must not serve
    point_p2 = 1'b1; tick(1); point_p2 = 1'b0;
    chk("lit_p2_score", int'(points_player_2), 1);
    chk("lit_p2_server", int'(server), 0);
    chk("lit_p2_ball_run", int'(ball_run), 0);
    frames(PAUSE);
    tick(3);
    chk("lit_held_serve", int'(ball_run), 0);
    serve = 1'b0; tick(1); serve = 1'b1; tick(1);
    chk("lit_reserve", int'(ball_run), 1);

    // Simultaneous points: only player 1 counts
    point_p1 = 1'b1; point_p2 = 1'b1; tick(1);
    point_p1 = 1'b0; point_p2 = 1'b0;
    chk("lit_both_p1", int'(points_player_1), 1);
    chk("lit_both_p2", int'(points_player_2), 1);
    chk("lit_both_server", int'(server), 1);

    // Fresh single-player match won 11-0 by player 1
    rst = 1'b0; tick(1); rst = 1'b1;
    start_single = 1'b1; tick(1); start_single = 1'b0;
    chk("lit_single_mode", int'(screen_multi), 0);
    for (int r = 0; r < WIN; r++) play_point(1);
    chk("lit_go_flag", int'(game_over), 1);
    chk("lit_go_winner", int'(winner), 0);
    chk("lit_go_score", int'(points_player_1), 11);
    frames(OVER);
    chk("lit_idle_after_go", int'(screen_idle), 1);
    chk("lit_idle_hold_p1", int'(points_player_1), 11);
    chk("lit_idle_hold_p2", int'(points_player_2), 0);

    // Player 2 wins; serve edge cuts the result screen short
    start_multi = 1'b1; tick(1); start_multi = 1'b0;
    for (int r = 0; r < WIN; r++) play_point(2);
    chk("lit_p2win_flag", int'(game_over), 1);
    chk("lit_p2win_winner", int'(winner), 1);
    serve = 1'b0; tick(1); serve = 1'b1; tick(1);
    chk("lit_serve_exit", int'(screen_idle), 1);
    chk("lit_winner_held", int'(winner), 1);

    // Reset in the middle of a pause
    start_multi = 1'b1; tick(1); start_multi = 1'b0;
    serve = 1'b0; tick(1); serve = 1'b1; tick(1);
    point_p1 = 1'b1; tick(1); point_p1 = 1'b0;
    frames(31);
    rst = 1'b0; tick(1); rst = 1'b1;
    chk("lit_rst_idle", int'(screen_idle), 1);
    chk("lit_rst_p1", int'(points_player_1), 0);
    chk("lit_rst_server", int'(server), 0);
    point_p1 = 1'b1; tick(1); point_p1 = 1'b0;
    point_p2 = 1'b1; tick(1); point_p2 = 1'b0;
    chk("lit_idle_pts_p1", int'(points_player_1), 0);
    chk("lit_idle_pts_p2", int'(points_player_2), 0);

    // Randomized run against the model
    for (int c = 0; c < 20000; c++) begin
      rst          = ($urandom_range(0, 4999) != 0);
      end_of_frame = ($urandom_range(0, 2) == 0);
      start_single = ($urandom_range(0, 19) == 0);
      start_multi  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 5) == 0) serve = ~serve;
      point_p1     = ($urandom_range(0, 7) == 0);
      point_p2     = ($urandom_range(0, 7) == 0);
      tick(1);
    end

    rst = 1'b1; end_of_frame = 1'b0; point_p1 = 1'b0; point_p2 = 1'b0;
    tick(1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
